// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine with HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [5:0]            i_alu_ctrl,
  input  logic [DATA_WIDTH-1:0] i_rs,
  input  logic [DATA_WIDTH-1:0] i_rt,
  input  logic                  i_flush,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX
  } state_t;

  state_t         r_state;
  logic           r_div;
  logic           r_uns;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_rs;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_dz;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;
  logic           r_done;

  logic           w_is_md;
  logic           w_sa;
  logic           w_sb;
  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic [W:0]     w_madd;
  logic [W:0]     w_dsh;
  logic [W:0]     w_dsub;
  logic           w_dge;
  logic [W-1:0]   w_rem;
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_q;
  logic [W-1:0]   w_r;

  assign w_is_md = (i_alu_ctrl == F_MULT) || (i_alu_ctrl == F_MULTU) ||
                   (i_alu_ctrl == F_DIV)  || (i_alu_ctrl == F_DIVU);

  assign w_sa    = ~r_uns & r_a[W-1];
  assign w_sb    = ~r_uns & r_b[W-1];
  assign w_abs_a = w_sa ? -r_a : r_a;
  assign w_abs_b = w_sb ? -r_b : r_b;

  // Multiply: acc = {partial high, remaining multiplier bits}
  assign w_madd = {1'b0, r_acc[2*W-1:W]} +
                  (r_acc[0] ? {1'b0, r_a} : '0);

  // Divide: acc = {partial remainder, dividend bits / quotient bits}
  assign w_dsh  = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_dsub = w_dsh - {1'b0, r_b};
  assign w_dge  = (w_dsh >= {1'b0, r_b});
  assign w_rem  = w_dge ? w_dsub[W-1:0] : w_dsh[W-1:0];

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_q    = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_r    = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_div   <= 1'b0;
      r_uns   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_rs    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start && !i_flush) begin
            if (w_is_md) begin
              r_div   <= i_alu_ctrl[1];
              r_uns   <= i_alu_ctrl[0];
              r_a     <= i_rs;
              r_b     <= i_rt;
              r_rs    <= i_rs;
              r_state <= S_PREP;
            end else if (i_alu_ctrl == F_MTHI) begin
              r_hi <= i_rs;
            end else if (i_alu_ctrl == F_MTLO) begin
              r_lo <= i_rs;
            end
          end
        end
        S_PREP: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else begin
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_dz    <= (r_b == '0);
            r_cnt   <= '0;
            if (r_div) begin
              r_b   <= w_abs_b;
              r_acc <= {{W{1'b0}}, w_abs_a};
            end else begin
              r_a   <= w_abs_a;
              r_acc <= {{W{1'b0}}, w_abs_b};
            end
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          if (i_flush) begin
            r_state <= S_IDLE;
          end else begin
            if (r_div)
              r_acc <= {w_rem, r_acc[W-2:0], w_dge};
            else
              r_acc <= {w_madd, r_acc[W-1:1]};
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(W - 1))
              r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          if (!i_flush) begin
            r_done <= 1'b1;
            if (!r_div) begin
              r_hi <= w_prod[2*W-1:W];
              r_lo <= w_prod[W-1:0];
            end else if (r_dz) begin
              r_hi <= r_rs;
              r_lo <= '1;
            end else begin
              r_hi <= w_r;
              r_lo <= w_q;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

  always_comb begin
    o_rd_data = '0;
    if (i_alu_ctrl == F_MFHI)
      o_rd_data = r_hi;
    else if (i_alu_ctrl == F_MFLO)
      o_rd_data = r_lo;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases
// plus random ops against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [5:0]  i_alu_ctrl;
  logic [31:0] i_rs;
  logic [31:0] i_rt;
  logic        i_flush;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic [31:0] o_rd_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_alu_ctrl (i_alu_ctrl),
    .i_rs       (i_rs),
    .i_rt       (i_rt),
    .i_flush    (i_flush),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_hi       (o_hi),
    .o_lo       (o_lo),
    .o_rd_data  (o_rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_md(input logic [5:0] c,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint p;
    int     sq;
    int     sr;
    logic [63:0] r;
    r = '0;
    case (c)
      6'h18: begin
        p = longint'($signed(a)) * longint'($signed(b));
        r = p;
      end
      6'h19: r = {32'h0, a} * {32'h0, b};
      6'h1a: begin
        if (b == 0)
          r = {a, 32'hffffffff};
        else if (a == 32'h80000000 && b == 32'hffffffff)
          r = {32'h0, 32'h80000000};
        else begin
          sq = $signed(a) / $signed(b);
          sr = $signed(a) % $signed(b);
          r = {sr, sq};
        end
      end
      6'h1b: begin
        if (b == 0)
          r = {a, 32'hffffffff};
        else
          r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [5:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    i_start    = 1'b1;
    i_alu_ctrl = c;
    i_rs       = a;
    i_rt       = b;
    @(negedge clk);
    i_start = 1'b0;
    i_rs    = $urandom;
    i_rt    = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (o_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_md(input string tag, input logic [5:0] c,
                        input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] e;
    issue(c, a, b);
    wait_idle(n);
    e = ref_md(c, a, b);
    m_hi = e[63:32];
    m_lo = e[31:0];
    chk({tag, "_busy"}, 64'(n), 64'd34);
    chk({tag, "_done"}, 64'(o_done), 64'd1);
    chk({tag, "_hi"}, 64'(o_hi), 64'(m_hi));
    chk({tag, "_lo"}, 64'(o_lo), 64'(m_lo));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(o_done), 64'd0);
  endtask

  task automatic chk_rd(input string tag);
    i_alu_ctrl = 6'h10;
    #1 chk({tag, "_mfhi"}, 64'(o_rd_data), 64'(m_hi));
    i_alu_ctrl = 6'h12;
    #1 chk({tag, "_mflo"}, 64'(o_rd_data), 64'(m_lo));
    i_alu_ctrl = 6'h18;
    #1 chk({tag, "_rdz"}, 64'(o_rd_data), 64'd0);
  endtask

  task automatic watch_no_done(input string tag, input int cyc);
    int d;
    d = 0;
    repeat (cyc) begin
      if (o_done) d++;
      @(negedge clk);
    end
    chk(tag, 64'(d), 64'd0);
  endtask

  initial begin
    int n;
    logic [5:0] codes [6];
    logic [5:0] c;
    logic [31:0] a;
    logic [31:0] b;
    codes = '{6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b};
    i_rst = 1'b1; i_start = 1'b0; i_alu_ctrl = 6'h0;
    i_rs = '0; i_rt = '0; i_flush = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_hi", 64'(o_hi), 64'd0);
    chk("rst_lo", 64'(o_lo), 64'd0);

    run_md("mult_neg", 6'h18, 32'hffffffff, 32'h2);
    run_md("multu", 6'h19, 32'hffffffff, 32'h2);
    run_md("div_neg", 6'h1a, 32'hfffffff9, 32'h2);
    run_md("divu_z", 6'h1b, 32'h7, 32'h0);
    run_md("div_z", 6'h1a, 32'hfffffff9, 32'h0);
    run_md("div_ovf", 6'h1a, 32'h80000000, 32'hffffffff);
    run_md("divu_big", 6'h1b, 32'h80000000, 32'hffffffff);
    chk_rd("rd0");

    // MTHI then MFHI
    issue(6'h11, 32'h1234, 32'h0);
    m_hi = 32'h1234;
    chk("mthi_done", 64'(o_done), 64'd0);
    chk("mthi_busy", 64'(o_busy), 64'd0);
    chk_rd("mthi");

    // Second start while busy must be ignored
    issue(6'h18, 32'h00010003, 32'hfffffffb);
    i_start = 1'b1; i_alu_ctrl = 6'h1a; i_rs = 32'h64; i_rt = 32'h7;
    @(negedge clk);
    i_start = 1'b0;
    wait_idle(n);
    {m_hi, m_lo} = ref_md(6'h18, 32'h00010003, 32'hfffffffb);
    chk("ovl_busy", 64'(n), 64'd33);
    chk("ovl_hi", 64'(o_hi), 64'(m_hi));
    chk("ovl_lo", 64'(o_lo), 64'(m_lo));
    @(negedge clk);
    chk("ovl_idle", 64'(o_busy), 64'd0);

    // Flush mid-operation
    issue(6'h18, 32'h12345678, 32'h9abcdef0);
    repeat (8) @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("flush_busy", 64'(o_busy), 64'd0);
    watch_no_done("flush_nodone", 40);
    chk("flush_hi", 64'(o_hi), 64'(m_hi));
    chk("flush_lo", 64'(o_lo), 64'(m_lo));

    // Flush in IDLE kills the same-cycle start
    i_flush = 1'b1;
    issue(6'h11, 32'hdeadbeef, 32'h0);
    chk("fidle_hi", 64'(o_hi), 64'(m_hi));
    i_alu_ctrl = 6'h19;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_flush = 1'b0;
    chk("fidle_busy", 64'(o_busy), 64'd0);

    // Unlisted code ignored
    issue(6'h20, 32'hcafef00d, 32'h3);
    chk("unl_busy", 64'(o_busy), 64'd0);
    chk("unl_hi", 64'(o_hi), 64'(m_hi));
    chk("unl_lo", 64'(o_lo), 64'(m_lo));

    // Reset mid-operation
    issue(6'h1a, 32'h7fffffff, 32'h3);
    repeat (5) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("mrst_busy", 64'(o_busy), 64'd0);
    watch_no_done("mrst_nodone", 40);
    chk("mrst_hi", 64'(o_hi), 64'd0);
    chk("mrst_lo", 64'(o_lo), 64'd0);

    for (int i = 0; i < 40; i++) begin
      c = codes[$urandom_range(0, 5)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 5) == 0) b = 32'h1 << $urandom_range(0, 31);
      if (c == 6'h11 || c == 6'h13) begin
        issue(c, a, b);
        if (c == 6'h11) m_hi = a;
        else m_lo = a;
        chk("rnd_mt_done", 64'(o_done), 64'd0);
        chk("rnd_mt_hi", 64'(o_hi), 64'(m_hi));
        chk("rnd_mt_lo", 64'(o_lo), 64'(m_lo));
      end else begin
        run_md("rnd", c, a, b);
      end
      chk_rd("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
